// File: rtl/sng_bi_tx_pkg.sv
// Shared constants and types for the bipolar stochastic number transmitter.
//   DATAWD_DEFAULT : default operand / LFSR width
//   STREAM_LEN     : beats per stream for the default width (one LFSR period)
//   SEED_DEFAULT   : seed substituted for an all-zero seed
//   state_t        : transmitter FSM states
//   lfsr_taps()    : XOR feedback mask of a maximal-length LFSR per width
package sng_pkg;

   localparam int DATAWD_DEFAULT = 8;
   localparam int STREAM_LEN     = 2**DATAWD_DEFAULT - 1;
   localparam int SEED_DEFAULT   = 1;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Bit i of the mask set means register bit i feeds the XOR.
   function automatic logic [31:0] lfsr_taps(input int n);
      case (n)
         3:       lfsr_taps = 32'h0000_0006;
         4:       lfsr_taps = 32'h0000_000C;
         5:       lfsr_taps = 32'h0000_0014;
         6:       lfsr_taps = 32'h0000_0030;
         7:       lfsr_taps = 32'h0000_0060;
         8:       lfsr_taps = 32'h0000_00B8;
         9:       lfsr_taps = 32'h0000_0110;
         10:      lfsr_taps = 32'h0000_0240;
         11:      lfsr_taps = 32'h0000_0500;
         12:      lfsr_taps = 32'h0000_0829;
         16:      lfsr_taps = 32'h0000_D008;
         default: lfsr_taps = 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/sng_bi_tx_lfsr.sv
// Fibonacci XOR LFSR (maximal length, all-zero is the only lock-up state).
//   clk, rst      : clock, async active-high reset (register -> SEED_DEFAULT)
//   i_Enable      : advance one step
//   i_Seed_DV     : load i_Seed_Data (wins over i_Enable)
//   i_Seed_Data   : seed value
//   o_LFSR_Data   : current register value
//   o_LFSR_Done   : register has returned to the last loaded seed
module lfsr
   import sng_pkg::*;
#(
   parameter int NUM_BITS = DATAWD_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_Enable,
   input  logic                i_Seed_DV,
   input  logic [NUM_BITS-1:0] i_Seed_Data,
   output logic [NUM_BITS-1:0] o_LFSR_Data,
   output logic                o_LFSR_Done
);

   localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(lfsr_taps(NUM_BITS));

   logic [NUM_BITS-1:0] lfsr_q;
   logic [NUM_BITS-1:0] seed_q;
   logic                feedback;

   assign feedback = ^(lfsr_q & TAPS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= NUM_BITS'(SEED_DEFAULT);
         seed_q <= NUM_BITS'(SEED_DEFAULT);
      end else if (i_Seed_DV) begin
         lfsr_q <= i_Seed_Data;
         seed_q <= i_Seed_Data;
      end else if (i_Enable) begin
         lfsr_q <= {lfsr_q[NUM_BITS-2:0], feedback};
      end
   end

   assign o_LFSR_Data = lfsr_q;
   assign o_LFSR_Done = (lfsr_q == seed_q);

endmodule

// File: rtl/sng_bi_tx.sv
// Bipolar stochastic number transmitter: turns operand iA into a serial
// bitstream of STREAM_LEN beats, oBit = (A > lfsr), one bit per accepted beat.
//   iA/iSeed/iValid/oReady : load handshake (accepted only in IDLE)
//   iAbort                 : drop the current stream (wins over acceptance)
//   oBit/oValid/iReady     : output beat with backpressure
//   oLast                  : final beat of the stream
//   oOnes                  : accepted one-bits since last load (SNG_ONES_CNT_EN)
// Optional feature macro: SNG_ONES_CNT_EN
//
// state  | meaning
// IDLE   | waiting for a load, oReady=1
// STREAM | emitting beats until last beat accepted or abort
module sng_bi_tx
   import sng_pkg::*;
#(
   parameter int DATAWD = DATAWD_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATAWD-1:0] iA,
   input  logic [DATAWD-1:0] iSeed,
   input  logic              iValid,
   output logic              oReady,
   input  logic              iAbort,
   output logic              oBit,
   output logic              oValid,
   input  logic              iReady,
`ifdef SNG_ONES_CNT_EN
   output logic [DATAWD-1:0] oOnes,
`endif
   output logic              oLast
);

   localparam int LEN = 2**DATAWD - 1;

   state_t            state, state_nxt;
   logic [DATAWD-1:0] a_buf;
   logic [DATAWD-1:0] cnt;
   logic [DATAWD-1:0] lfsr_val;
   logic [DATAWD-1:0] seed_sub;
   logic              stream, load, accept, last_beat;
   logic              unused_lfsr_done;

   assign stream    = (state == STREAM);
   assign load      = !stream && iValid;
   assign accept    = stream && iReady && !iAbort;
   assign last_beat = (cnt == DATAWD'(LEN - 1));
   assign seed_sub  = (iSeed == '0) ? DATAWD'(SEED_DEFAULT) : iSeed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = STREAM;
         STREAM:  if (iAbort || (accept && last_beat)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_buf <= '0;
         cnt   <= '0;
      end else if (load) begin
         a_buf <= iA;
         cnt   <= '0;
      end else if (accept) begin
         cnt   <= cnt + 1'b1;
      end
   end

   lfsr #(.NUM_BITS(DATAWD)) u_lfsr (
      .clk         (clk),
      .rst         (rst),
      .i_Enable    (accept),
      .i_Seed_DV   (load),
      .i_Seed_Data (seed_sub),
      .o_LFSR_Data (lfsr_val),
      .o_LFSR_Done (unused_lfsr_done)
   );

   assign oReady = !stream;
   assign oValid = stream;
   assign oBit   = stream && (a_buf > lfsr_val);
   assign oLast  = stream && last_beat;

`ifdef SNG_ONES_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  oOnes <= '0;
      else if (load)            oOnes <= '0;
      else if (accept && oBit)  oOnes <= oOnes + 1'b1;
   end
`endif

endmodule

// File: tb/tb_sng_bi_tx.sv
module tb_sng_bi_tx;

   logic       clk = 0;
   logic       rst = 1;
   logic [7:0] iA = 0, iSeed = 0;
   logic       iValid = 0, iAbort = 0, iReady = 0;
   logic       oReady, oBit, oValid, oLast;
`ifdef SNG_ONES_CNT_EN
   logic [7:0] oOnes;
`endif

   int tests = 0, fails = 0;

   sng_bi_tx #(.DATAWD(8)) dut (
      .clk(clk), .rst(rst), .iA(iA), .iSeed(iSeed), .iValid(iValid),
      .oReady(oReady), .iAbort(iAbort), .oBit(oBit), .oValid(oValid),
      .iReady(iReady),
`ifdef SNG_ONES_CNT_EN
      .oOnes(oOnes),
`endif
      .oLast(oLast)
   );

   always #5 clk = ~clk;

   // results of the last run_stream call
   logic [255:0] r_seq, ref_seq;
   int  r_ones, r_beats, r_cycles, r_last_err, r_stall_err;
   bit  r_done, r_timeout, r_first, r_ready_after, r_valid_after;

   function automatic int exp_ones(input int a);
      return (a == 0) ? 0 : a - 1;
   endfunction

   task automatic do_load(input logic [7:0] a, input logic [7:0] s);
      @(negedge clk);
      iA = a; iSeed = s; iValid = 1;
      @(posedge clk); #1;
      iValid = 0; iA = 8'($urandom); iSeed = 8'($urandom);
   endtask

   // Collect beats until the oLast beat is accepted or stop_after beats taken.
   task automatic run_stream(input int stop_after, input bit stall, input bit noise);
      bit pend = 0, prev = 0;
      r_seq = '0; r_ones = 0; r_beats = 0; r_cycles = 0;
      r_last_err = 0; r_stall_err = 0; r_done = 0; r_timeout = 0; r_first = 0;
      for (int c = 0; c < 3000; c++) begin
         iReady = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         iValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         iA     = 8'($urandom);
         #3;
         r_cycles++;
         if (!oValid) begin r_stall_err++; break; end
         if (pend && oBit !== prev) r_stall_err++;
         if (iReady) begin
            if (r_beats == 0) r_first = oBit;
            r_seq[r_beats] = oBit;
            r_ones += int'(oBit);
            r_beats++;
            if (oLast !== (r_beats == 255)) r_last_err++;
            if (oLast) r_done = 1;
            pend = 0;
         end else begin
            if (oLast !== (r_beats == 254)) r_last_err++;
            pend = 1; prev = oBit;
         end
         @(posedge clk); #1;
         if (r_done || (stop_after != 0 && r_beats == stop_after)) break;
      end
      iValid = 0; iReady = 0;
      if (!r_done && (stop_after == 0 || r_beats != stop_after)) r_timeout = 1;
      r_ready_after = oReady; r_valid_after = oValid;
   endtask

   task automatic test_reset;
      iValid = 1;
      #12;
      tests++; if (oReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", oReady); end
      tests++; if ({oValid, oBit, oLast} !== 3'b000) begin fails++; $display("FAIL reset_outs: got %b want 000", {oValid, oBit, oLast}); end
      @(negedge clk); iValid = 0; rst = 0;
      @(negedge clk);
      tests++; if (oReady !== 1'b1 || oValid !== 1'b0) begin fails++; $display("FAIL idle_after_reset: ready %b valid %b want 1 0", oReady, oValid); end
   endtask

   task automatic test_basic;
      do_load(8'h80, 8'h01);
      run_stream(0, 0, 0);
      ref_seq = r_seq;
      tests++; if (r_timeout) begin fails++; $display("FAIL basic_timeout: beats %0d want 255", r_beats); end
      tests++; if (r_beats != 255 || r_cycles != 255) begin fails++; $display("FAIL basic_len: beats %0d cycles %0d want 255 255", r_beats, r_cycles); end
      tests++; if (r_ones != 127) begin fails++; $display("FAIL basic_ones: got %0d want 127", r_ones); end
      tests++; if (r_last_err != 0 || r_stall_err != 0) begin fails++; $display("FAIL basic_last: last_err %0d valid_err %0d want 0 0", r_last_err, r_stall_err); end
      tests++; if (r_first !== 1'b1) begin fails++; $display("FAIL basic_first: got %b want 1", r_first); end
      tests++; if (r_ready_after !== 1'b1 || r_valid_after !== 1'b0) begin fails++; $display("FAIL basic_end: ready %b valid %b want 1 0", r_ready_after, r_valid_after); end
`ifdef SNG_ONES_CNT_EN
      repeat (3) @(posedge clk); #1;
      tests++; if (oOnes !== 8'd127) begin fails++; $display("FAIL basic_oones: got %0d want 127", oOnes); end
`endif
   endtask

   task automatic test_corners;
      logic [7:0] av [3] = '{8'h00, 8'hFF, 8'h01};
      for (int i = 0; i < 3; i++) begin
         logic [7:0] s = 8'($urandom_range(1, 255));
         do_load(av[i], s);
         run_stream(0, 0, 0);
         tests++; if (r_beats != 255 || r_ones != exp_ones(int'(av[i]))) begin fails++; $display("FAIL corner_ones A=%0h: beats %0d ones %0d want 255 %0d", av[i], r_beats, r_ones, exp_ones(int'(av[i]))); end
         tests++; if (r_first !== (av[i] > s)) begin fails++; $display("FAIL corner_first A=%0h: got %b want %b", av[i], r_first, av[i] > s); end
      end
   endtask

   task automatic test_stall;
      do_load(8'h80, 8'h01);
      run_stream(0, 1, 0);
      tests++; if (r_beats != 255 || r_seq !== ref_seq) begin fails++; $display("FAIL stall_seq: beats %0d seq %h want 255 %h", r_beats, r_seq, ref_seq); end
      tests++; if (r_stall_err != 0 || r_last_err != 0) begin fails++; $display("FAIL stall_hold: hold_err %0d last_err %0d want 0 0", r_stall_err, r_last_err); end
   endtask

   task automatic test_seed_zero;
      do_load(8'h80, 8'h00);
      run_stream(0, 0, 0);
      tests++; if (r_beats != 255 || r_seq !== ref_seq) begin fails++; $display("FAIL seed0_seq: beats %0d seq %h want 255 %h", r_beats, r_seq, ref_seq); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] a = 8'($urandom), s = 8'($urandom);
         logic [7:0] es = (s == 0) ? 8'h01 : s;
         do_load(a, s);
         run_stream(0, 1, 1);
         tests++; if (r_beats != 255 || r_ones != exp_ones(int'(a)) || r_stall_err != 0 || r_last_err != 0) begin
            fails++; $display("FAIL random_stream A=%0h S=%0h: beats %0d ones %0d errs %0d/%0d want 255 %0d 0/0", a, s, r_beats, r_ones, r_stall_err, r_last_err, exp_ones(int'(a)));
         end
         tests++; if (r_first !== (a > es)) begin fails++; $display("FAIL random_first A=%0h S=%0h: got %b want %b", a, s, r_first, a > es); end
      end
   endtask

   task automatic test_reset_mid;
      do_load(8'h80, 8'h01);
      run_stream(100, 0, 0);
      rst = 1; #1;
      tests++; if (oValid !== 1'b0 || oReady !== 1'b1 || oLast !== 1'b0) begin fails++; $display("FAIL midrst_outs: valid %b ready %b last %b want 0 1 0", oValid, oReady, oLast); end
      @(negedge clk); rst = 0;
      do_load(8'h40, 8'($urandom_range(1, 255)));
      run_stream(0, 0, 0);
      tests++; if (r_beats != 255 || r_ones != 63) begin fails++; $display("FAIL midrst_reload: beats %0d ones %0d want 255 63", r_beats, r_ones); end
   endtask

   task automatic test_abort;
      int ones49;
      do_load(8'h80, 8'h01);
      run_stream(49, 0, 0);
      ones49 = r_ones;
      tests++; if (r_beats != 49 || r_last_err != 0) begin fails++; $display("FAIL abort_pre: beats %0d last_err %0d want 49 0", r_beats, r_last_err); end
      iAbort = 1; iReady = 1; #3;
      tests++; if (oValid !== 1'b1 || oLast !== 1'b0) begin fails++; $display("FAIL abort_beat50: valid %b last %b want 1 0", oValid, oLast); end
      @(posedge clk); #1; iAbort = 0; iReady = 0;
      tests++; if (oValid !== 1'b0 || oReady !== 1'b1) begin fails++; $display("FAIL abort_idle: valid %b ready %b want 0 1", oValid, oReady); end
`ifdef SNG_ONES_CNT_EN
      tests++; if (int'(oOnes) != ones49) begin fails++; $display("FAIL abort_oones: got %0d want %0d", oOnes, ones49); end
`endif
      // abort while idle must not block a load
      @(negedge clk); iA = 8'hC3; iSeed = 8'h5A; iValid = 1; iAbort = 1;
      @(posedge clk); #1; iValid = 0; iAbort = 0;
      tests++; if (oValid !== 1'b1 || oReady !== 1'b0) begin fails++; $display("FAIL abort_idle_load: valid %b ready %b want 1 0", oValid, oReady); end
      run_stream(0, 0, 0);
      tests++; if (r_beats != 255 || r_ones != 8'hC3 - 1) begin fails++; $display("FAIL abort_after: beats %0d ones %0d want 255 %0d", r_beats, r_ones, 8'hC3 - 1); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_corners;
      test_stall;
      test_seed_zero;
      test_random;
      test_reset_mid;
      test_abort;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sng_bi_tx.md
Name: sng_bi_tx

Overview:
Bipolar stochastic number transmitter: converts one DATAWD-bit binary operand into a serial stochastic bitstream, one bit per accepted beat.
- Operand is offset-binary bipolar: x = 2*A/2^DATAWD - 1.
- Sits upstream of the stochastic multiply/count units and drives their operand bit inputs.
- Input uses a valid/ready load handshake; output uses valid/ready with backpressure and a last-beat marker.

Parameters:
DATAWD, 8, operand width and LFSR width.
STREAM_LEN, 2**DATAWD-1, beats per stream (one full maximal-length LFSR period).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
iA  in  DATAWD  binary operand, sampled on load handshake.
iSeed  in  DATAWD  LFSR seed, sampled on load handshake.
iValid  in  1  load request.
oReady  out  1  block idle; accepts a load.
iAbort  in  1  terminate the current stream.
oBit  out  1  stochastic bit.
oValid  out  1  oBit valid.
iReady  in  1  downstream accepts the beat.
oLast  out  1  marks final beat, qualified by oValid.

Behaviour:
- Reset: one clock, asynchronous active-high reset. While rst=1 the block is in IDLE and all outputs are 0 except oReady=1.
- State machine has two states.
- IDLE:
  - oReady=1, oValid=0.
  - On iValid&&oReady at a clock edge: A_buf<=iA, LFSR seed loaded, beat counter<=0, go to STREAM.
  - If iSeed==0, seed 8'h01 (SEED_DEFAULT) is loaded instead, which prevents LFSR lock-up.
- STREAM:
  - oReady=0; iValid is ignored.
  - oValid=1, oBit = (A_buf > lfsr_value) as an unsigned compare.
  - Beat accepted when oValid&&iReady. On acceptance: LFSR advances, counter increments.
  - When iReady=0: LFSR, counter and oBit hold stable.
  - oLast=1 when counter==STREAM_LEN-1. When that beat is accepted, go to IDLE (oReady=1 the next cycle).
- Latency: first bit is valid the cycle after the load handshake. A stream with no stalls finishes in STREAM_LEN cycles.
- Counting guarantee: over a full stream from any nonzero seed the LFSR visits 1..2^DATAWD-1 exactly once. Ones emitted = max(A-1, 0).
- iAbort:
  - In STREAM, iAbort=1 goes to IDLE at the next edge; oLast is not asserted.
  - iAbort takes priority over beat acceptance in the same cycle; that beat is dropped.
  - In IDLE, iAbort has no effect.
- Reset mid-stream: immediate IDLE, stream discarded.
- Counter width: DATAWD bits; it never wraps because the stream ends at STREAM_LEN-1.

Optional Feature:
Macro SNG_ONES_CNT_EN.
- Defined: adds output oOnes [DATAWD-1:0]:
  - Counts accepted beats with oBit=1.
  - Cleared on load handshake and on reset.
  - Holds its final value in IDLE until the next load.
  - Used for in-system self-check against max(A-1, 0).
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package sng_pkg holds: DATAWD default, STREAM_LEN constant, SEED_DEFAULT=1, and the state typedef (IDLE, STREAM).
- Sub-module: instantiate the codebase lfsr with NUM_BITS=DATAWD.
  - enable = beat accepted.
  - i_Seed_DV = load handshake.
  - i_Seed_Data = substituted seed.
  - o_LFSR_Done unused.

Test Plan:
- A=0x80, seed=0x01, iReady=1 constant -> 255 consecutive valid beats, 127 ones, oLast only on beat 255, oReady=1 on the following cycle.
- A=0x00 -> 0 ones; A=0xFF -> 254 ones; A=0x01 -> 0 ones; all over 255 beats.
- A=0x80, seed=0x01, iReady random 50% -> bit sequence identical to the first test, 255 accepted beats, oBit stable during every stall.
- seed=0x00 -> bit sequence identical to seed=0x01 with the same A.
- rst asserted at beat 100 -> oValid=0 and oReady=1 immediately. After release, a load with A=0x40 yields 63 ones.
- iAbort at beat 50 with iReady=1 -> next cycle IDLE, oLast never seen. With SNG_ONES_CNT_EN, oOnes equals the ones counted in beats 1-49.
